// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM transmit path.
package ppm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    USER_DATA,
    WAIT_START,
    SEND_SOF,
    SEND_DATA,
    SEND_EOF
  } state_t;

  localparam logic [7:0] SOF_CODE      = 8'h7E;
  localparam logic [7:0] EOF_CODE      = 8'h81;
  localparam int         PPM_MAX_BYTES = 16;

endpackage

// File: rtl/ppm_tx_sequencer_if.sv
// Byte-level strobe/done handshake between the frame sequencer and the 2-bit-symbol shifter.
interface ppm_tx_sequencer_if;

  logic [7:0] shift_data;
  logic       shift_strobe;
  logic       shift_done;

  modport master (output shift_data, output shift_strobe, input shift_done);
  modport slave  (input shift_data, input shift_strobe, output shift_done);

endinterface

// File: rtl/ppm_frame_ram.sv
// Payload buffer: synchronous write, combinational read.
module ppm_frame_ram #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ppm_tx_sequencer.sv
// Frame controller: buffers a 1-16 byte user frame, then feeds the shifter SOF, payload, EOF
// one byte per strobe/done handshake.
module ppm_tx_sequencer
  import ppm_pkg::*;
#(
  parameter int DEPTH = PPM_MAX_BYTES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Le,
  input  logic [3:0]                 N,
  input  logic [7:0]                 Din,
  input  logic                       start_trans,
  output logic                       user_recv_done,
  output logic                       busy,
  output logic                       frame_done,
  ppm_tx_sequencer_if.master         shf
);

  state_t      state, state_n;
  logic [4:0]  wr_cnt, wr_cnt_n;
  logic [3:0]  rd_ptr, rd_ptr_n;
  logic [3:0]  n_lat, n_lat_n;
  logic        wait_done, wait_done_n;
  logic        strobe_q, strobe_n;
  logic [7:0]  data_q, data_n;
  logic        recv_n, busy_n, fd_n;
  logic        we;
  logic [3:0]  waddr, raddr;
  logic [7:0]  rdata;
  logic        done_ok;

  // A done only counts once a strobe is outstanding and never in the strobe cycle itself.
  assign done_ok = wait_done && !strobe_q && shf.shift_done;

  // Look ahead one byte so the next payload strobe can follow the done by a single cycle.
  assign raddr = (state == SEND_DATA && done_ok) ? rd_ptr + 4'd1 : rd_ptr;

  ppm_frame_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (Din),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wr_cnt         <= '0;
      rd_ptr         <= '0;
      n_lat          <= '0;
      wait_done      <= 1'b0;
      strobe_q       <= 1'b0;
      data_q         <= '0;
      user_recv_done <= 1'b0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_n;
      wr_cnt         <= wr_cnt_n;
      rd_ptr         <= rd_ptr_n;
      n_lat          <= n_lat_n;
      wait_done      <= wait_done_n;
      strobe_q       <= strobe_n;
      data_q         <= data_n;
      user_recv_done <= recv_n;
      busy           <= busy_n;
      frame_done     <= fd_n;
    end
  end

  always_comb begin
    state_n     = state;
    wr_cnt_n    = wr_cnt;
    rd_ptr_n    = rd_ptr;
    n_lat_n     = n_lat;
    wait_done_n = wait_done;
    strobe_n    = 1'b0;
    data_n      = data_q;
    recv_n      = 1'b0;
    busy_n      = busy;
    fd_n        = 1'b0;
    we          = 1'b0;
    waddr       = wr_cnt[3:0];

    case (state)
      IDLE: begin
        if (Le) begin
          we       = 1'b1;
          waddr    = 4'd0;
          wr_cnt_n = 5'd1;
          rd_ptr_n = 4'd0;
          n_lat_n  = N;
          busy_n   = 1'b1;
          if (N == 4'd0) begin
            state_n = WAIT_START;
            recv_n  = 1'b1;
          end else begin
            state_n = USER_DATA;
          end
        end
      end
      USER_DATA: begin
        if (Le) begin
          we       = 1'b1;
          wr_cnt_n = wr_cnt + 5'd1;
          if (wr_cnt == {1'b0, n_lat}) begin
            state_n = WAIT_START;
            recv_n  = 1'b1;
          end
        end
      end
      WAIT_START: begin
        if (start_trans) begin
          state_n     = SEND_SOF;
          strobe_n    = 1'b1;
          data_n      = SOF_CODE;
          wait_done_n = 1'b1;
          rd_ptr_n    = 4'd0;
        end
      end
      SEND_SOF: begin
        if (done_ok) begin
          state_n  = SEND_DATA;
          strobe_n = 1'b1;
          data_n   = rdata;
        end
      end
      SEND_DATA: begin
        if (done_ok) begin
          strobe_n = 1'b1;
          if (rd_ptr == n_lat) begin
            state_n = SEND_EOF;
            data_n  = EOF_CODE;
          end else begin
            rd_ptr_n = rd_ptr + 4'd1;
            data_n   = rdata;
          end
        end
      end
      SEND_EOF: begin
        if (done_ok) begin
          state_n     = IDLE;
          fd_n        = 1'b1;
          busy_n      = 1'b0;
          wait_done_n = 1'b0;
          wr_cnt_n    = '0;
          rd_ptr_n    = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign shf.shift_strobe = strobe_q;
  assign shf.shift_data   = data_q;

endmodule
